// File: rtl/pingpong_seq.sv
// pingpong_seq: sequencer for the dual-bank ping-pong frame buffer between the
// pixel loader (producer) and the layer compute engine (consumer).
//
// Write FSM
//   state   | meaning
//   W_FILL  | write bank open, every s_valid word is written
//   W_WAIT  | write bank full, waiting for the buffer to swap banks
//
// Read FSM
//   state   | meaning
//   R_BOOT  | first cycle out of reset; releases the empty read bank once
//   R_WAIT  | read bank released, waiting for the buffer to swap banks
//   R_READY | read bank full and idle, waiting for rd_start
//   R_ISSUE | issuing one pass of NODE read requests, stalled by rd_pause
//
// The buffer latches both done pulses and swaps a few cycles after the later
// one; both FSMs sit in their WAIT states across the swap cycle, so no write
// or read strobe can land in a swap cycle and be dropped.
module pingpong_seq #(
  parameter int DWIDTH = 8,
  parameter int NODE   = 784,
  parameter int PASSES = 1,
  parameter int CWIDTH = $clog2(NODE),
  parameter int PWIDTH = $clog2(PASSES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DWIDTH-1:0] s_data,
  output logic              s_ready,
  input  logic              rd_start,
  input  logic              rd_pause,
  output logic              rd_ready,
  output logic              pass_done,
  output logic              pp_w_valid,
  output logic [DWIDTH-1:0] pp_din,
  output logic              pp_done_write,
  output logic              pp_r_request,
  output logic              pp_done_read,
  input  logic              pp_swap,
  output logic [15:0]       swap_count
);

  typedef enum logic [0:0] {
    W_FILL = 1'b0,
    W_WAIT = 1'b1
  } wstate_t;

  typedef enum logic [1:0] {
    R_BOOT  = 2'd0,
    R_WAIT  = 2'd1,
    R_READY = 2'd2,
    R_ISSUE = 2'd3
  } rstate_t;

  localparam logic [CWIDTH-1:0] LAST_WORD  = CWIDTH'(NODE - 1);
  localparam logic [CWIDTH-1:0] CNT_ONE    = CWIDTH'(1);
  localparam logic [PWIDTH-1:0] PASS_LIMIT = PWIDTH'(PASSES);
  localparam logic [PWIDTH-1:0] PASS_ONE   = PWIDTH'(1);

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  wstate_t           w_state, w_state_nxt;
  logic [CWIDTH-1:0] wcnt, wcnt_nxt;
  logic              done_write_nxt;
  logic              w_handshake;

  // Write FSM state, word counter and registered write-done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state       <= W_FILL;
      wcnt          <= '0;
      pp_done_write <= 1'b0;
    end else begin
      w_state       <= w_state_nxt;
      wcnt          <= wcnt_nxt;
      pp_done_write <= done_write_nxt;
    end
  end

  // Write FSM next state: count handshakes, close the bank on the last word.
  always_comb begin
    w_state_nxt    = w_state;
    wcnt_nxt       = wcnt;
    done_write_nxt = 1'b0;
    s_ready        = 1'b0;
    w_handshake    = 1'b0;
    case (w_state)
      W_FILL: begin
        s_ready     = 1'b1;
        w_handshake = s_valid;
        if (w_handshake) begin
          if (wcnt == LAST_WORD) begin
            wcnt_nxt       = '0;
            done_write_nxt = 1'b1;
            w_state_nxt    = W_WAIT;
          end else begin
            wcnt_nxt = wcnt + CNT_ONE;
          end
        end
      end
      W_WAIT: begin
        if (pp_swap) begin
          w_state_nxt = W_FILL;
        end
      end
      default: begin
        w_state_nxt = W_FILL;
      end
    endcase
  end

  assign pp_w_valid = w_handshake;
  assign pp_din     = s_data;

  // ---------------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------------
  rstate_t           r_state, r_state_nxt;
  logic [CWIDTH-1:0] rcnt, rcnt_nxt;
  logic [PWIDTH-1:0] pcnt, pcnt_nxt, pcnt_inc;
  logic              pass_done_nxt;
  logic              done_read_nxt;
  logic              r_issue;

  // Read FSM state, word/pass counters and registered pass/read-done pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= R_BOOT;
      rcnt         <= '0;
      pcnt         <= '0;
      pass_done    <= 1'b0;
      pp_done_read <= 1'b0;
    end else begin
      r_state      <= r_state_nxt;
      rcnt         <= rcnt_nxt;
      pcnt         <= pcnt_nxt;
      pass_done    <= pass_done_nxt;
      pp_done_read <= done_read_nxt;
    end
  end

  // Read FSM next state: bootstrap, wait for swap, run passes, release bank.
  always_comb begin
    r_state_nxt   = r_state;
    rcnt_nxt      = rcnt;
    pcnt_nxt      = pcnt;
    pcnt_inc      = pcnt + PASS_ONE;
    pass_done_nxt = 1'b0;
    done_read_nxt = 1'b0;
    rd_ready      = 1'b0;
    r_issue       = 1'b0;
    case (r_state)
      R_BOOT: begin
        // Nothing was ever written to the read bank; hand it straight back.
        done_read_nxt = 1'b1;
        r_state_nxt   = R_WAIT;
      end
      R_WAIT: begin
        if (pp_swap) begin
          pcnt_nxt    = '0;
          r_state_nxt = R_READY;
        end
      end
      R_READY: begin
        rd_ready = 1'b1;
        if (rd_start) begin
          rcnt_nxt    = '0;
          r_state_nxt = R_ISSUE;
        end
      end
      R_ISSUE: begin
        r_issue = ~rd_pause;
        if (r_issue) begin
          if (rcnt == LAST_WORD) begin
            rcnt_nxt      = '0;
            pass_done_nxt = 1'b1;
            pcnt_nxt      = pcnt_inc;
            if (pcnt_inc < PASS_LIMIT) begin
              r_state_nxt = R_READY;
            end else begin
              done_read_nxt = 1'b1;
              r_state_nxt   = R_WAIT;
            end
          end else begin
            rcnt_nxt = rcnt + CNT_ONE;
          end
        end
      end
      default: begin
        r_state_nxt = R_WAIT;
      end
    endcase
  end

  assign pp_r_request = r_issue;

  // ---------------------------------------------------------------------------
  // Swap counter
  // ---------------------------------------------------------------------------

  // Count every swap cycle seen from the buffer; wraps naturally at 2^16.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      swap_count <= '0;
    end else if (pp_swap) begin
      swap_count <= swap_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pingpong_seq.sv
// tb_pingpong_seq: directed bench for pingpong_seq with NODE=8. Instance 0 runs
// PASSES=1, instance 1 runs PASSES=2. The bench models the buffer (done latches
// and delayed one-cycle swap), scoreboards write data and counts strobes/pulses.
module tb_pingpong_seq;
  localparam int DW = 8;
  localparam int N  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          s_valid [2];
  logic [DW-1:0] s_data [2];
  logic          s_ready [2];
  logic          rd_start [2];
  logic          rd_pause [2];
  logic          rd_ready [2];
  logic          pass_done [2];
  logic          pp_w_valid [2];
  logic [DW-1:0] pp_din [2];
  logic          pp_done_write [2];
  logic          pp_r_request [2];
  logic          pp_done_read [2];
  logic          pp_swap [2];
  logic [15:0]   swap_count [2];

  pingpong_seq #(.DWIDTH(DW), .NODE(N), .PASSES(1)) u_p1 (
    .clk(clk), .rst(rst),
    .s_valid(s_valid[0]), .s_data(s_data[0]), .s_ready(s_ready[0]),
    .rd_start(rd_start[0]), .rd_pause(rd_pause[0]), .rd_ready(rd_ready[0]),
    .pass_done(pass_done[0]), .pp_w_valid(pp_w_valid[0]), .pp_din(pp_din[0]),
    .pp_done_write(pp_done_write[0]), .pp_r_request(pp_r_request[0]),
    .pp_done_read(pp_done_read[0]), .pp_swap(pp_swap[0]), .swap_count(swap_count[0])
  );

  pingpong_seq #(.DWIDTH(DW), .NODE(N), .PASSES(2)) u_p2 (
    .clk(clk), .rst(rst),
    .s_valid(s_valid[1]), .s_data(s_data[1]), .s_ready(s_ready[1]),
    .rd_start(rd_start[1]), .rd_pause(rd_pause[1]), .rd_ready(rd_ready[1]),
    .pass_done(pass_done[1]), .pp_w_valid(pp_w_valid[1]), .pp_din(pp_din[1]),
    .pp_done_write(pp_done_write[1]), .pp_r_request(pp_r_request[1]),
    .pp_done_read(pp_done_read[1]), .pp_swap(pp_swap[1]), .swap_count(swap_count[1])
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;
  int n_wr [2], n_rd [2], n_dw [2], n_dr [2], n_pd [2], n_swap [2], n_viol [2];
  int last_hs_cyc = 0;
  int dw_cyc = 0;
  logic [DW-1:0] wq [$];

  logic smp_dw [2], smp_dr [2], lat_w [2], lat_r [2];
  int   lat_age [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sample outputs mid-cycle: write scoreboard, strobe/pulse counters, swap rule.
  task automatic monitor();
    logic [31:0] exp_w;
    for (int g = 0; g < 2; g++) begin
      smp_dw[g] = pp_done_write[g];
      smp_dr[g] = pp_done_read[g];
      if (pp_w_valid[g] === 1'b1) begin
        n_wr[g]++;
        last_hs_cyc = cyc_n;
        exp_w = (wq.size() > 0) ? 32'(wq.pop_front()) : 32'hFFFF_FFFF;
        check("write data", 32'(pp_din[g]), exp_w);
      end
      if (pp_r_request[g] === 1'b1) begin
        n_rd[g]++;
        if (rd_pause[g]) n_viol[g]++;
      end
      if (pp_done_write[g]) begin
        n_dw[g]++;
        dw_cyc = cyc_n;
      end
      if (pp_done_read[g]) n_dr[g]++;
      if (pass_done[g]) n_pd[g]++;
      if (pp_swap[g]) begin
        n_swap[g]++;
        check("strobe during swap", 32'({pp_w_valid[g], pp_r_request[g]}), 32'd0);
      end
    end
  endtask

  // Buffer model: latch both done pulses, swap for one cycle two cycles later.
  task automatic buf_step();
    for (int g = 0; g < 2; g++) begin
      if (!rst) begin
        lat_w[g] = 1'b0; lat_r[g] = 1'b0; lat_age[g] = 0; pp_swap[g] = 1'b0;
      end else if (pp_swap[g]) begin
        pp_swap[g] = 1'b0;
      end else begin
        if (smp_dw[g]) lat_w[g] = 1'b1;
        if (smp_dr[g]) lat_r[g] = 1'b1;
        if (lat_w[g] && lat_r[g]) begin
          if (lat_age[g] >= 2) begin
            pp_swap[g] = 1'b1; lat_w[g] = 1'b0; lat_r[g] = 1'b0; lat_age[g] = 0;
          end else begin
            lat_age[g]++;
          end
        end
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    cyc_n++;
    monitor();
    @(posedge clk);
    #1;
    buf_step();
  endtask

  task automatic write_words(input int g, input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      s_valid[g] = 1'b1;
      s_data[g]  = base + DW'(i);
      wq.push_back(base + DW'(i));
      cyc();
    end
    s_valid[g] = 1'b0;
  endtask

  task automatic wait_swap(input int g, input string tag);
    int start;
    start = n_swap[g];
    for (int k = 0; k < 40 && n_swap[g] == start; k++) cyc();
    check(tag, 32'(n_swap[g] - start), 32'd1);
  endtask

  initial begin
    int r0, r1, dr0, dr1, pd0, w0, dw0;
    for (int g = 0; g < 2; g++) begin
      s_valid[g] = 1'b0; s_data[g] = '0; rd_start[g] = 1'b0; rd_pause[g] = 1'b0;
      pp_swap[g] = 1'b0; smp_dw[g] = 1'b0; smp_dr[g] = 1'b0;
      lat_w[g] = 1'b0; lat_r[g] = 1'b0; lat_age[g] = 0;
      n_wr[g] = 0; n_rd[g] = 0; n_dw[g] = 0; n_dr[g] = 0; n_pd[g] = 0;
      n_swap[g] = 0; n_viol[g] = 0;
    end

    // Reset state
    repeat (3) cyc();
    for (int g = 0; g < 2; g++) begin
      check("reset outputs", 32'({pp_done_write[g], pp_done_read[g], pass_done[g],
            rd_ready[g], pp_w_valid[g], pp_r_request[g]}), 32'd0);
      check("reset swap_count", 32'(swap_count[g]), 32'd0);
      check("reset s_ready", 32'(s_ready[g]), 32'd1);
    end

    // Bootstrap pulse one cycle after release
    rst = 1'b1;
    cyc();
    check("boot done_read p1", 32'(pp_done_read[0]), 32'd1);
    check("boot done_read p2", 32'(pp_done_read[1]), 32'd1);
    cyc();
    check("boot done_read pulse width", 32'(pp_done_read[0]), 32'd0);
    check("boot done_read count", 32'(n_dr[0]), 32'd1);

    // Test 1: first frame, continuous s_valid
    write_words(0, N, 8'h10);
    check("t1 done_write", 32'(pp_done_write[0]), 32'd1);
    check("t1 s_ready in wait", 32'(s_ready[0]), 32'd0);
    s_valid[0] = 1'b1;
    s_data[0]  = 8'hEE;
    cyc();
    check("t1 done_write latency", 32'(dw_cyc - last_hs_cyc), 32'd1);
    check("t1 done_write pulse width", 32'(pp_done_write[0]), 32'd0);
    wait_swap(0, "t1 swap");
    s_valid[0] = 1'b0;
    check("t1 swap_count", 32'(swap_count[0]), 32'd1);
    check("t1 rd_ready after swap", 32'(rd_ready[0]), 32'd1);
    check("t1 s_ready after swap", 32'(s_ready[0]), 32'd1);
    check("t1 words written", 32'(n_wr[0]), 32'd8);

    // Test 2: one read pass, then frame 2 gates the next swap
    r0 = n_rd[0]; pd0 = n_pd[0]; dr0 = n_dr[0];
    rd_start[0] = 1'b1;
    cyc();
    rd_start[0] = 1'b0;
    check("t2 no issue in ready", 32'(n_rd[0] - r0), 32'd0);
    repeat (N) cyc();
    check("t2 requests", 32'(n_rd[0] - r0), 32'd8);
    check("t2 pass_done", 32'(pass_done[0]), 32'd1);
    check("t2 done_read", 32'(pp_done_read[0]), 32'd1);
    check("t2 rd_ready in wait", 32'(rd_ready[0]), 32'd0);
    rd_start[0] = 1'b1;
    repeat (4) cyc();
    rd_start[0] = 1'b0;
    check("t2 rd_start ignored", 32'(n_rd[0] - r0), 32'd8);
    check("t2 pass_done once", 32'(n_pd[0] - pd0), 32'd1);
    check("t2 done_read once", 32'(n_dr[0] - dr0), 32'd1);
    write_words(0, N - 1, 8'h20);
    repeat (5) cyc();
    check("t2 no swap before frame 2", 32'(swap_count[0]), 32'd1);
    write_words(0, 1, 8'h27);
    wait_swap(0, "t2 swap");
    check("t2 swap_count", 32'(swap_count[0]), 32'd2);

    // Test 3: PASSES=2 instance
    write_words(1, N, 8'h40);
    wait_swap(1, "t3 swap");
    check("t3 rd_ready", 32'(rd_ready[1]), 32'd1);
    r1 = n_rd[1]; dr1 = n_dr[1];
    rd_start[1] = 1'b1;
    cyc();
    rd_start[1] = 1'b0;
    repeat (N) cyc();
    check("t3 pass1 requests", 32'(n_rd[1] - r1), 32'd8);
    check("t3 pass1 pass_done", 32'(pass_done[1]), 32'd1);
    check("t3 pass1 no done_read", 32'(pp_done_read[1]), 32'd0);
    check("t3 pass1 rd_ready", 32'(rd_ready[1]), 32'd1);
    cyc();
    rd_start[1] = 1'b1;
    cyc();
    rd_start[1] = 1'b0;
    repeat (N) cyc();
    check("t3 pass2 requests", 32'(n_rd[1] - r1), 32'd16);
    check("t3 pass2 done_read", 32'(pp_done_read[1]), 32'd1);
    check("t3 pass2 rd_ready", 32'(rd_ready[1]), 32'd0);
    cyc();
    check("t3 done_read count", 32'(n_dr[1] - dr1), 32'd1);

    // Test 4: rd_pause toggling every cycle
    r0 = n_rd[0];
    rd_start[0] = 1'b1;
    cyc();
    rd_start[0] = 1'b0;
    for (int k = 0; k < 16; k++) begin
      rd_pause[0] = (k % 2 == 0);
      cyc();
    end
    rd_pause[0] = 1'b0;
    check("t4 requests", 32'(n_rd[0] - r0), 32'd8);
    check("t4 issue during pause", 32'(n_viol[0]), 32'd0);
    check("t4 done_read", 32'(pp_done_read[0]), 32'd1);

    // Test 5: simultaneous completion of write and read banks
    write_words(0, N, 8'h60);
    wait_swap(0, "t5 pre swap");
    check("t5 swap_count before", 32'(swap_count[0]), 32'd3);
    rd_start[0] = 1'b1;
    cyc();
    rd_start[0] = 1'b0;
    write_words(0, N, 8'h80);
    check("t5 done_write", 32'(pp_done_write[0]), 32'd1);
    check("t5 done_read", 32'(pp_done_read[0]), 32'd1);
    wait_swap(0, "t5 swap");
    check("t5 swap_count", 32'(swap_count[0]), 32'd4);
    repeat (8) cyc();
    check("t5 single swap", 32'(swap_count[0]), 32'd4);

    // Test 6: reset after 5 writes and 3 reads
    r0 = n_rd[0]; w0 = n_wr[0];
    rd_start[0] = 1'b1;
    s_valid[0] = 1'b1; s_data[0] = 8'hC0; wq.push_back(8'hC0);
    cyc();
    rd_start[0] = 1'b0;
    for (int i = 1; i < 4; i++) begin
      s_data[0] = 8'hC0 + DW'(i); wq.push_back(8'hC0 + DW'(i));
      cyc();
    end
    rd_pause[0] = 1'b1;
    s_data[0] = 8'hC4; wq.push_back(8'hC4);
    cyc();
    s_valid[0] = 1'b0;
    check("t6 partial writes", 32'(n_wr[0] - w0), 32'd5);
    check("t6 partial reads", 32'(n_rd[0] - r0), 32'd3);
    rst = 1'b0;
    rd_pause[0] = 1'b0;
    buf_step();
    #1;
    check("t6 reset outputs", 32'({pp_done_write[0], pp_done_read[0], pass_done[0],
          rd_ready[0], pp_w_valid[0], pp_r_request[0]}), 32'd0);
    check("t6 reset swap_count", 32'(swap_count[0]), 32'd0);
    repeat (2) cyc();
    rst = 1'b1;
    dr0 = n_dr[0]; dw0 = n_dw[0];
    cyc();
    check("t6 boot done_read", 32'(pp_done_read[0]), 32'd1);
    cyc();
    check("t6 boot done_read once", 32'(n_dr[0] - dr0), 32'd1);
    write_words(0, N - 1, 8'hA0);
    repeat (6) cyc();
    check("t6 no done_write after 7", 32'(n_dw[0] - dw0), 32'd0);
    check("t6 no swap after 7", 32'(swap_count[0]), 32'd0);
    write_words(0, 1, 8'hA7);
    check("t6 done_write", 32'(pp_done_write[0]), 32'd1);
    wait_swap(0, "t6 swap");
    check("t6 swap_count", 32'(swap_count[0]), 32'd1);
    check("write queue drained", 32'(wq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
